// File: rtl/draw_request_arbiter.sv
// Arbitrates sprite draw requesters onto the single plotter/VGA write path.
// Latency: req edge -> pending next edge -> registered one-hot grant the edge after (when IDLE).
// Backpressure: requests are buffered in pending; grant is held until plot_done or timeout abort.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration (fixed priority otherwise).
module draw_request_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int TIMEOUT = 100000,
    parameter int TO_W    = 17
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               plot_done,
    input  logic               clear_err,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic [NUM_REQ-1:0] done,
    output logic               timeout_err
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] pending, pending_nxt;
    logic [NUM_REQ-1:0] grant_nxt, done_nxt;
    logic [NUM_REQ-1:0] win_mask;
    logic [IDX_W-1:0]   winner, winner_nxt;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic [TO_W-1:0]    counter, counter_nxt;
    logic               err_nxt;
`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt, winner_inc;
    int                 cand;
`endif

    // One-hot mask of the requester currently being served.
    assign win_mask = NUM_REQ'(1) << winner;
    assign busy     = (state != IDLE) || (|pending);

`ifdef ARB_ROUND_ROBIN_EN
    assign winner_inc = (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);

    // Round-robin pick: first pending index at or after rr_ptr, wrapping to 0.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!sel_found && pending[cand[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
    end
`else
    // Fixed-priority pick: lowest pending index wins (background first).
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (pending[k]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(k);
            end
        end
    end
`endif

    // Next-state and output logic for the IDLE -> GRANT -> FLUSH cycle.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending | req;
        grant_nxt   = grant;
        done_nxt    = '0;
        winner_nxt  = winner;
        counter_nxt = counter;
        err_nxt     = timeout_err & ~clear_err;
`ifdef ARB_ROUND_ROBIN_EN
        rr_ptr_nxt  = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (sel_found) begin
                    winner_nxt  = sel_idx;
                    grant_nxt   = NUM_REQ'(1) << sel_idx;
                    counter_nxt = '0;
                    state_nxt   = GRANT;
                end
            end
            GRANT: begin
                counter_nxt = counter + TO_W'(1);
                // Completion beats timeout when both land on the same cycle.
                if (plot_done) begin
                    done_nxt    = win_mask;
                    grant_nxt   = '0;
                    pending_nxt = (pending & ~win_mask) | req;
                    state_nxt   = FLUSH;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_ptr_nxt  = winner_inc;
`endif
                end else if (counter == TO_LAST) begin
                    err_nxt     = 1'b1;
                    grant_nxt   = '0;
                    pending_nxt = (pending & ~win_mask) | req;
                    state_nxt   = FLUSH;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_ptr_nxt  = winner_inc;
`endif
                end
            end
            FLUSH: begin
                // One dead cycle so the datapath's delayed plot/x/y can drain.
                grant_nxt = '0;
                state_nxt = IDLE;
            end
            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= '0;
            grant       <= '0;
            done        <= '0;
            winner      <= '0;
            counter     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            pending     <= pending_nxt;
            grant       <= grant_nxt;
            done        <= done_nxt;
            winner      <= winner_nxt;
            counter     <= counter_nxt;
            timeout_err <= err_nxt;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_draw_request_arbiter.sv
// Directed bench for draw_request_arbiter with a short timeout.
// Inputs change and outputs are sampled 1ns after each rising edge.
// Expected values are hand-derived from the arbiter's cycle behaviour.
module tb_draw_request_arbiter;
    localparam int NUM_REQ = 8;
    localparam int TIMEOUT = 20;
    localparam int TO_W    = 5;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic [7:0] T3_FIRST  = 8'h08;
    localparam logic [7:0] T3_SECOND = 8'h02;
`else
    localparam logic [7:0] T3_FIRST  = 8'h02;
    localparam logic [7:0] T3_SECOND = 8'h08;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = '0;
    logic       plot_done = 1'b0;
    logic       clear_err = 1'b0;
    logic [7:0] grant;
    logic       busy;
    logic [7:0] done;
    logic       timeout_err;

    int checks = 0;
    int failures = 0;

    draw_request_arbiter #(
        .NUM_REQ(NUM_REQ),
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .plot_done  (plot_done),
        .clear_err  (clear_err),
        .grant      (grant),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic pulse_req(input logic [7:0] v);
        req = v;
        step(1);
        req = '0;
    endtask

    // Raise plot_done for one edge, then check the completion pulse and FLUSH.
    task automatic finish_grant(input string tag, input logic [7:0] exp_done);
        plot_done = 1'b1;
        step(1);
        plot_done = 1'b0;
        chk8({tag, "_done"}, done, exp_done);
        chk8({tag, "_flush_grant"}, grant, 8'h00);
        step(1);
        chk8({tag, "_done_clr"}, done, 8'h00);
        chk8({tag, "_idle_grant"}, grant, 8'h00);
    endtask

    initial begin
        // Reset state
        step(2);
        reset = 1'b0;
        chk8("rst_grant", grant, 8'h00);
        chk8("rst_done", done, 8'h00);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", timeout_err, 1'b0);

        // 1: single request, completes after a few cycles
        pulse_req(8'h01);
        chk8("t1_pend_grant", grant, 8'h00);
        chk1("t1_pend_busy", busy, 1'b1);
        step(1);
        chk8("t1_grant", grant, 8'h01);
        step(9);
        chk8("t1_grant_held", grant, 8'h01);
        finish_grant("t1", 8'h01);
        chk1("t1_busy_end", busy, 1'b0);

        // plot_done while idle is ignored
        plot_done = 1'b1;
        step(1);
        plot_done = 1'b0;
        chk8("idle_pd_done", done, 8'h00);
        chk8("idle_pd_grant", grant, 8'h00);

        // 2: two requests in one cycle, lower index first
        pulse_req(8'h0A);
        step(1);
        chk8("t2_first", grant, 8'h02);
        finish_grant("t2a", 8'h02);
        chk1("t2_busy_mid", busy, 1'b1);
        step(1);
        chk8("t2_second", grant, 8'h08);
        finish_grant("t2b", 8'h08);
        chk1("t2_busy_end", busy, 1'b0);

        // 3: serve bit 1 alone, then bits 1 and 3 together
        pulse_req(8'h02);
        step(1);
        chk8("t3_pre", grant, 8'h02);
        finish_grant("t3_pre", 8'h02);
        pulse_req(8'h0A);
        step(1);
        chk8("t3_first", grant, T3_FIRST);
        finish_grant("t3a", T3_FIRST);
        step(1);
        chk8("t3_second", grant, T3_SECOND);
        finish_grant("t3b", T3_SECOND);
        chk1("t3_busy_end", busy, 1'b0);

        // 4: re-request in the same cycle as completion
        pulse_req(8'h08);
        step(1);
        chk8("t4_grant", grant, 8'h08);
        req = 8'h08;
        plot_done = 1'b1;
        step(1);
        req = '0;
        plot_done = 1'b0;
        chk8("t4_done", done, 8'h08);
        chk8("t4_flush_grant", grant, 8'h00);
        step(1);
        chk1("t4_busy_idle", busy, 1'b1);
        chk8("t4_idle_grant", grant, 8'h00);
        step(1);
        chk8("t4_regrant", grant, 8'h08);
        finish_grant("t4b", 8'h08);
        chk1("t4_busy_end", busy, 1'b0);

        // 5: timeout abort, then clear
        pulse_req(8'h04);
        step(1);
        chk8("t5_grant", grant, 8'h04);
        step(TIMEOUT - 1);
        chk8("t5_grant_last", grant, 8'h04);
        chk1("t5_err_pre", timeout_err, 1'b0);
        step(1);
        chk8("t5_abort_grant", grant, 8'h00);
        chk1("t5_err", timeout_err, 1'b1);
        chk8("t5_no_done", done, 8'h00);
        step(1);
        chk1("t5_pending_clr", busy, 1'b0);
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        chk1("t5_err_clr", timeout_err, 1'b0);

        // clear_err on the same cycle as a new timeout keeps the error
        pulse_req(8'h04);
        step(TIMEOUT);
        chk8("t5b_grant_last", grant, 8'h04);
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        chk1("t5b_err_kept", timeout_err, 1'b1);
        chk8("t5b_abort_grant", grant, 8'h00);
        step(1);
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        chk1("t5b_err_clr", timeout_err, 1'b0);

        // plot_done coinciding with timeout counts as completion
        pulse_req(8'h04);
        step(TIMEOUT);
        chk8("t5c_grant_last", grant, 8'h04);
        finish_grant("t5c", 8'h04);
        chk1("t5c_no_err", timeout_err, 1'b0);
        chk1("t5c_busy_end", busy, 1'b0);

        // 6: reset mid-grant
        pulse_req(8'h05);
        step(1);
        chk8("t6_grant", grant, 8'h01);
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk8("t6_rst_grant", grant, 8'h00);
        chk1("t6_rst_busy", busy, 1'b0);
        chk8("t6_rst_done", done, 8'h00);
        plot_done = 1'b1;
        step(1);
        plot_done = 1'b0;
        chk8("t6_late_pd_done", done, 8'h00);
        chk8("t6_late_pd_grant", grant, 8'h00);
        step(1);
        chk8("t6_after_done", done, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
